// File: rtl/scan_select.sv
// Select sequencer for a 2-to-4 decoder. It steps {s1,s0} through the masked-in
// positions at a programmable slot rate and pulses sweep_done when the sweep wraps.
module scan_select #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [3:0]       mask,
  input  logic             one_shot,
  output logic             s0,
  output logic             s1,
  output logic             valid,
  output logic             busy,
  output logic             sweep_done
);

  localparam int unsigned IDX_W = 2;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       mask_q, mask_d;
  logic             one_shot_q, one_shot_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W:0]   above_c;

  // Lowest set bit of m; the caller guarantees m is non-zero.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [3:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit of m strictly above cur.
  function automatic logic [IDX_W:0] next_above(input logic [3:0] m, input logic [IDX_W-1:0] cur);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      presc_q    <= '0;
      div_q      <= '0;
      mask_q     <= '0;
      one_shot_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      presc_q    <= presc_d;
      div_q      <= div_d;
      mask_q     <= mask_d;
      one_shot_q <= one_shot_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    presc_d    = presc_q;
    div_d      = div_q;
    mask_d     = mask_q;
    one_shot_d = one_shot_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    above_c    = next_above(mask_q, idx_q);

    unique case (state_q)
      IDLE: begin
        if (start && !stop && (mask != 4'b0000)) begin
          state_d    = RUN;
          mask_d     = mask;
          div_d      = div;
          one_shot_d = one_shot;
          idx_d      = lowest_set(mask);
          presc_d    = '0;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = '0;
          presc_d = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (en) begin
          if (presc_q == div_q) begin
            presc_d = '0;
            if (above_c[IDX_W]) begin
              idx_d = above_c[IDX_W-1:0];
            end else begin
              // Wrap: the sweep is complete.
              done_d = 1'b1;
              if (one_shot_q) begin
                state_d = IDLE;
                idx_d   = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
              end else begin
                idx_d = lowest_set(mask_q);
              end
            end
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s0         = idx_q[0];
  assign s1         = idx_q[1];
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_scan_select.sv
// Directed self-checking bench for scan_select: sweeps, one-shot, stall,
// start rejection, stop priority, single-bit mask and asynchronous reset.
module tb_scan_select;

  localparam int unsigned DIV_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             en;
  logic [DIV_W-1:0] div;
  logic [3:0]       mask;
  logic             one_shot;
  logic             s0, s1, valid, busy, sweep_done;

  int n_cmp = 0;
  int n_err = 0;

  scan_select #(.DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .en         (en),
    .div        (div),
    .mask       (mask),
    .one_shot   (one_shot),
    .s0         (s0),
    .s1         (s1),
    .valid      (valid),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare {s1,s0,valid,busy,sweep_done} against the expected values.
  task automatic chk(input string tag, input int k, input logic [1:0] e_idx,
                     input logic e_v, input logic e_b, input logic e_d);
    logic [4:0] obs, exp;
    obs = {s1, s0, valid, busy, sweep_done};
    exp = {e_idx, e_v, e_b, e_d};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d observed {s1s0,v,b,d}=%b required %b", tag, k, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b1;
    div = '0; mask = 4'b0000; one_shot = 1'b0;
    step(); step();
    chk("reset", 0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", 0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Continuous sweep over full mask, 3-cycle slots; inputs scrambled after start.
    mask = 4'b1111; div = 8'd2; one_shot = 1'b0; start = 1'b1;
    step();
    chk("full_start", 0, 2'd0, 1'b1, 1'b1, 1'b0);
    start = 1'b0; mask = 4'b0001; div = 8'd0; one_shot = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
      chk("full_sweep", k, 2'((k / 3) % 4), 1'b1, 1'b1, 1'((k % 12) == 0));
    end
    stop = 1'b1;
    step();
    chk("full_stop", 0, 2'd0, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    // One-shot over sparse mask 1010 with div=0.
    mask = 4'b1010; div = 8'd0; one_shot = 1'b1; start = 1'b1;
    step();
    chk("os_first", 0, 2'd1, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    step();
    chk("os_second", 1, 2'd3, 1'b1, 1'b1, 1'b0);
    step();
    chk("os_done", 2, 2'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk("os_idle", 3, 2'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("os_idle", 4, 2'd0, 1'b0, 1'b0, 1'b0);

    // Stall on index 2 with div=3.
    mask = 4'b1111; div = 8'd3; one_shot = 1'b0; start = 1'b1;
    step();
    chk("stall_start", 0, 2'd0, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("stall_pre", k, 2'(k / 4), 1'b1, 1'b1, 1'b0);
    end
    en = 1'b0;
    for (int k = 10; k <= 14; k++) begin
      step();
      chk("stall_hold", k, 2'd2, 1'b1, 1'b1, 1'b0);
    end
    en = 1'b1;
    step();
    chk("stall_resume", 15, 2'd2, 1'b1, 1'b1, 1'b0);
    step();
    chk("stall_resume", 16, 2'd2, 1'b1, 1'b1, 1'b0);
    for (int k = 17; k <= 20; k++) begin
      step();
      chk("stall_idx3", k, 2'd3, 1'b1, 1'b1, 1'b0);
    end
    // Next edge is a wrap tick; stop must suppress sweep_done.
    stop = 1'b1;
    step();
    chk("stop_on_wrap", 21, 2'd0, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;
    step();
    chk("stop_after", 22, 2'd0, 1'b0, 1'b0, 1'b0);

    // Start rejected with empty mask, and stop beating start.
    mask = 4'b0000; div = 8'd0; start = 1'b1;
    step();
    chk("start_mask0", 0, 2'd0, 1'b0, 1'b0, 1'b0);
    mask = 4'b1111; stop = 1'b1;
    step();
    chk("start_stop", 0, 2'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b0;
    step();
    chk("still_idle", 0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Single-bit mask 0100, div=1, continuous.
    mask = 4'b0100; div = 8'd1; one_shot = 1'b0; start = 1'b1;
    step();
    chk("single_start", 0, 2'd2, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("single_run", k, 2'd2, 1'b1, 1'b1, 1'((k % 2) == 0));
    end

    // Asynchronous reset between edges while running.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 0, 2'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("async_hold", 1, 2'd0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("after_release", k, 2'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scan_select.md
# scan_select

Upstream select sequencer for the 2-to-4 active-high decoder. It steps a 2-bit select code `{s1,s0}` through the enabled decoder outputs at a programmable rate, so exactly one decoder output is active per slot. It skips positions that are masked off and signals the end of each full sweep. It runs either continuously or for a single sweep.

## Interface
- `DIV_W`, default 8: width of the slot-length divider.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: level sampled each cycle; begins a scan from IDLE.
- `stop`, input, 1: synchronous abort back to IDLE.
- `en`, input, 1: advance enable. When low, the block stalls.
- `div`, input, DIV_W: slot length minus one, in enabled cycles. Captured at start.
- `mask`, input, 4: `mask[i]` = 1 includes index i in the sweep. Captured at start.
- `one_shot`, input, 1: 1 = stop after one sweep. Captured at start.
- `s0`, output, 1: select LSB to the decoder.
- `s1`, output, 1: select MSB to the decoder. Index = `{s1,s0}`.
- `valid`, output, 1: the select code is meaningful and the decoder output may be used.
- `busy`, output, 1: the block is in RUN.
- `sweep_done`, output, 1: one-cycle pulse on completion of a sweep.

## Operation
- There are two states: IDLE and RUN. All outputs are registered.
- **Reset:** `s1,s0` = 00, `valid` = 0, `busy` = 0, `sweep_done` = 0, prescaler = 0, state = IDLE.
- **IDLE → RUN** requires `start`=1, `stop`=0 and `mask`≠0000 in the same cycle. On that edge the block:
  - latches `mask`, `div` and `one_shot`;
  - loads the index with the lowest set bit of `mask`;
  - clears the prescaler;
  - sets `valid`=1 and `busy`=1.
- **Ignored start:** `start` with `mask`=0000 has no effect. `start` while in RUN is ignored.
- **Prescaler:** in RUN with `en`=1, the prescaler counts 0..div. At count==div (a "tick") it resets to 0 and the index advances. With `en`=0, the prescaler and index hold and `valid` stays 1.
- **Advance rule:** the next index is the next set bit of the latched mask strictly above the current index. If no higher bit is set, the index wraps to the lowest set bit. A wrap marks sweep completion.
- **On a wrap tick:**
  - `sweep_done`=1 for exactly that cycle.
  - If `one_shot`=1: go to IDLE with `s1,s0`=00, `valid`=0, `busy`=0.
  - Otherwise: continue with the wrapped index.
- **Single set bit:** the index never changes. Every tick is a wrap and pulses `sweep_done`.
- **`stop`=1 in RUN:** go to IDLE next edge with outputs as at reset. `sweep_done` is not asserted, even if that cycle is a wrap tick.
- **`start` and `stop` together in IDLE:** stop wins and the block stays IDLE.
- **Input changes during RUN:** changes to `mask`, `div` and `one_shot` have no effect until the next start.
- **Arithmetic:** the prescaler is DIV_W bits unsigned, compared for equality with the latched div, so it never overflows. The index is 2 bits.

## Timing
- **Start latency:** `start` sampled at edge N → `valid`, `busy` and the first index are visible after edge N.
- **Slot length:** each slot lasts exactly div+1 cycles with `en`=1. Cycles with `en`=0 stretch the slot one-for-one.
- **div=0:** the index advances every enabled cycle.
- **`sweep_done` timing:** asserted in the same cycle the index changes to the wrapped value (or the cycle `valid` drops, in one_shot).
- **Decoder path:** the decoder is combinational on `s1,s0`, so the decoder outputs follow the index in the same cycle.
- **Asynchronous reset:** asserting `rst_n` low mid-scan forces reset values immediately, without waiting for a clock edge. After release, the block idles until a new `start`.

## Test plan
- **Continuous, full mask:** reset; `mask`=1111, `div`=2, `one_shot`=0, pulse `start` → index 0,1,2,3,0 with 3 cycles each; `sweep_done` pulses once per 12 cycles, on the 3→0 change; `busy`=1 throughout.
- **One-shot, sparse mask:** `mask`=1010, `div`=0, `one_shot`=1, `start` → index 1 for 1 cycle, index 3 for 1 cycle, then `sweep_done`=1, `valid`=0, `busy`=0, `s1,s0`=00; the block stays IDLE.
- **Stall with `en`:** `mask`=1111, `div`=3; drop `en` for 5 cycles mid-slot on index 2 → index 2 held for 4+5 enabled-plus-stalled cycles; no skipped or extra advances.
- **Start rejected / stop priority:** `start` with `mask`=0000 → `busy` stays 0. `start`+`stop` together in IDLE → no start. `stop` on a wrap tick → IDLE and no `sweep_done`.
- **Single-bit mask:** `mask`=0100, `div`=1, continuous → `s1,s0`=10 constantly; `sweep_done` every 2nd cycle.
- **Async reset mid-scan:** pull `rst_n` low between edges during RUN → outputs reach reset values before the next edge. After release, the block is IDLE with no spurious `valid` until `start`.
